// File: rtl/pzbcm_lzd_seq.sv
// Multi-cycle leading-zero/leading-one counter: latches a normalised vector and
// scans it one CHUNK-bit slice per cycle from bit 0 upward, stopping at the first hit.
module pzbcm_lzd_seq #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16,
    localparam int CHUNKS = (WIDTH + CHUNK - 1) / CHUNK,
    localparam int COUNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_clear,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_bits,
    input  logic                   i_from_msb,
    input  logic                   i_count_ones,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic                   o_all
);

    localparam int PAD_WIDTH = CHUNKS * CHUNK;
    localparam int IDX_WIDTH = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state;
    state_e                 state_next;
    logic [IDX_WIDTH-1:0]   idx;
    logic [PAD_WIDTH-1:0]   data;
    logic [PAD_WIDTH-1:0]   norm_bits;
    logic [CHUNK-1:0]       slice;
    logic                   slice_hit;
    logic [COUNT_WIDTH-1:0] slice_pos;
    logic [COUNT_WIDTH-1:0] hit_count;
    logic                   accept;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; o_valid holds with a stable result until i_ready, only reset/clear drop it.
    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign accept  = i_valid && o_ready;

    // Bit-reverse for MSB-first and invert for ones-counting, so the scan is always
    // a search for the lowest set bit; the padding above WIDTH stays zero.
    always_comb begin
        norm_bits = '0;
        for (int i = 0; i < WIDTH; i++) begin
            norm_bits[i] = (i_from_msb ? i_bits[WIDTH-1-i] : i_bits[i]) ^ i_count_ones;
        end
    end

    always_comb begin
        slice = '0;
        for (int c = 0; c < CHUNKS; c++) begin
            if (idx == IDX_WIDTH'(c)) begin
                slice = data[c*CHUNK +: CHUNK];
            end
        end
    end

    always_comb begin
        slice_hit = |slice;
        slice_pos = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (slice[i]) begin
                slice_pos = COUNT_WIDTH'(i);
            end
        end
        hit_count = COUNT_WIDTH'(idx) * COUNT_WIDTH'(CHUNK) + slice_pos;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = SCAN;
            SCAN:    if (slice_hit || (idx == LAST_IDX)) state_next = DONE;
            DONE:    if (i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_rst || i_clear) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            idx     <= '0;
            data    <= '0;
            o_count <= '0;
            o_all   <= 1'b0;
        end else if (i_clear) begin
            idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        data <= norm_bits;
                        idx  <= '0;
                    end
                end
                SCAN: begin
                    if (slice_hit) begin
                        o_count <= hit_count;
                        o_all   <= 1'b0;
                    end else if (idx == LAST_IDX) begin
                        o_count <= COUNT_WIDTH'(WIDTH);
                        o_all   <= 1'b1;
                    end else begin
                        idx <= idx + IDX_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pzbcm_lzd_seq.sv
// Directed bench for pzbcm_lzd_seq: a 64/16 instance (A) and a 20/8 partial-slice
// instance (B) share clock, reset, clear and mode inputs; each has its own handshakes.
module tb_pzbcm_lzd_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [63:0] bits;
    logic        from_msb;
    logic        count_ones;

    logic        a_valid, a_ready, a_res_valid, a_res_ready, a_all;
    logic [6:0]  a_count;
    logic        b_valid, b_ready, b_res_valid, b_res_ready, b_all;
    logic [4:0]  b_count;

    logic [63:0] exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pzbcm_lzd_seq #(.WIDTH(64), .CHUNK(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_valid(a_valid), .o_ready(a_ready), .i_bits(bits),
        .i_from_msb(from_msb), .i_count_ones(count_ones),
        .o_valid(a_res_valid), .i_ready(a_res_ready),
        .o_count(a_count), .o_all(a_all)
    );

    pzbcm_lzd_seq #(.WIDTH(20), .CHUNK(8)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_clear(clear),
        .i_valid(b_valid), .o_ready(b_ready), .i_bits(bits[19:0]),
        .i_from_msb(from_msb), .i_count_ones(count_ones),
        .o_valid(b_res_valid), .i_ready(b_res_ready),
        .o_count(b_count), .o_all(b_all)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic res_valid(input bit sel);
        return sel ? b_res_valid : a_res_valid;
    endfunction

    function automatic logic in_ready(input bit sel);
        return sel ? b_ready : a_ready;
    endfunction

    function automatic logic [63:0] res_count(input bit sel);
        return sel ? 64'(b_count) : 64'(a_count);
    endfunction

    function automatic logic res_all(input bit sel);
        return sel ? b_all : a_all;
    endfunction

    // Called at a negedge with the DUT idle; returns at the first negedge after accept.
    task automatic start_req(input bit sel, input logic [63:0] v, input logic msb, input logic ones);
        check("ready_before_req", in_ready(sel), 1'b1);
        bits       = v;
        from_msb   = msb;
        count_ones = ones;
        if (sel) b_valid = 1'b1; else a_valid = 1'b1;
        @(negedge clk);
        a_valid    = 1'b0;
        b_valid    = 1'b0;
        bits       = {$urandom, $urandom};
        from_msb   = 1'($urandom_range(0, 1));
        count_ones = 1'($urandom_range(0, 1));
    endtask

    // Latency is reported in cycles after the accept cycle.
    task automatic wait_result(input bit sel, output int lat);
        int n;
        n = 0;
        while (!res_valid(sel) && n < 50) begin
            @(negedge clk);
            n++;
        end
        lat = n + 1;
    endtask

    task automatic release_result(input bit sel, input string name);
        if (sel) b_res_ready = 1'b1; else a_res_ready = 1'b1;
        @(negedge clk);
        a_res_ready = 1'b0;
        b_res_ready = 1'b0;
        check({name, ".after_release"}, {res_valid(sel), in_ready(sel)}, 2'b01);
    endtask

    task automatic transact(input string name, input bit sel, input logic [63:0] v,
                            input logic msb, input logic ones, input logic [63:0] exp_cnt,
                            input logic exp_all, input int exp_lat, input int hold);
        int          lat;
        logic [63:0] exp;
        logic        stable;
        exp_q.push_back(exp_cnt);
        start_req(sel, v, msb, ones);
        wait_result(sel, lat);
        exp = exp_q.pop_front();
        check({name, ".latency"}, 64'(lat), 64'(exp_lat));
        check({name, ".count"}, res_count(sel), exp);
        check({name, ".all"}, res_all(sel), exp_all);
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (!res_valid(sel) || res_count(sel) !== exp || in_ready(sel) !== 1'b0) stable = 1'b0;
        end
        if (hold > 0) check({name, ".hold_stable"}, stable, 1'b1);
        release_result(sel, name);
    endtask

    initial begin
        int   lat;
        logic seen;
        rst = 1'b1; clear = 1'b0; bits = '0; from_msb = 1'b0; count_ones = 1'b0;
        a_valid = 1'b0; a_res_ready = 1'b0; b_valid = 1'b0; b_res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.a_ready", a_ready, 1'b1);
        check("reset.a_valid", a_res_valid, 1'b0);
        check("reset.a_count", 64'(a_count), 64'd0);
        check("reset.a_all", a_all, 1'b0);
        check("reset.b_ready_valid", {b_ready, b_res_valid}, 2'b10);
        rst = 1'b0;
        @(negedge clk);

        transact("msb_slice2",   1'b0, 64'h0000_0000_0010_0000, 1'b1, 1'b0, 64'd43, 1'b0, 4, 0);
        transact("msb_top",      1'b0, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'd0,  1'b0, 2, 0);
        transact("lsb_top",      1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 64'd63, 1'b0, 5, 0);
        transact("zeros_all",    1'b0, 64'h0,                   1'b0, 1'b0, 64'd64, 1'b1, 5, 0);
        transact("ones_all",     1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 64'd64, 1'b1, 5, 0);
        transact("ones_lsb_16",  1'b0, 64'hFFFF_FFFF_FFF0_FFFF, 1'b0, 1'b1, 64'd16, 1'b0, 3, 10);
        transact("ones_msb_8",   1'b0, 64'hFF00_0000_0000_0000, 1'b1, 1'b1, 64'd8,  1'b0, 2, 0);
        transact("b_zeros_all",  1'b1, 64'h0,                   1'b0, 1'b0, 64'd20, 1'b1, 4, 0);
        transact("b_msb_19",     1'b1, 64'h0_0001,              1'b1, 1'b0, 64'd19, 1'b0, 4, 0);
        transact("b_msb_0",      1'b1, 64'h8_0000,              1'b1, 1'b0, 64'd0,  1'b0, 2, 0);
        transact("b_ones_lsb_9", 1'b1, 64'hF_FDFF,              1'b0, 1'b1, 64'd9,  1'b0, 3, 0);

        // Clear together with a request in IDLE: the request must not be accepted.
        bits = 64'h1; clear = 1'b1; a_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0; a_valid = 1'b0;
        check("clear_idle.ready", a_ready, 1'b1);
        check("clear_idle.valid", a_res_valid, 1'b0);

        // Clear mid-scan at idx=1 on an all-zero vector.
        start_req(1'b0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("clear_scan.valid", a_res_valid, 1'b0);
        check("clear_scan.ready", a_ready, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_res_valid) seen = 1'b1;
        end
        check("clear_scan.no_valid", seen, 1'b0);
        transact("after_clear", 1'b0, 64'h1, 1'b0, 1'b0, 64'd0, 1'b0, 2, 0);

        // Reset while a result is waiting in DONE.
        start_req(1'b0, 64'h1, 1'b1, 1'b0);
        wait_result(1'b0, lat);
        check("rst_done.count", 64'(a_count), 64'd63);
        check("rst_done.latency", 64'(lat), 64'd5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_done.valid", a_res_valid, 1'b0);
        check("rst_done.ready", a_ready, 1'b1);
        check("rst_done.count_cleared", 64'(a_count), 64'd0);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pzbcm_lzd_seq.md
Name: pzbcm_lzd_seq

Overview:
- Multi-cycle leading-zero/leading-one counter for wide vectors.
- Scans the latched input one CHUNK-bit slice per cycle, with early termination on the first slice that contains a hit.
- Uses valid/ready handshakes on both the input and result sides.
- Successor to the combinational LZD: adds runtime scan direction, runtime zero/one detection, backpressure, and abort. Sits in normalisation, allocation and priority-search paths where WIDTH is too wide for a single-cycle count.

Parameters:
- WIDTH, 64, bit width of the searched vector (>=2).
- CHUNK, 16, bits examined per cycle (>=1, <=WIDTH).
- CHUNKS, derived = ceil(WIDTH/CHUNK), number of scan steps.
- COUNT_WIDTH, derived = $clog2(WIDTH+1), width of the count result.

Ports:
- i_clk  input  1  clock.
- i_rst  input  1  synchronous active-high reset.
- i_clear  input  1  synchronous abort; discards any in-flight operation.
- i_valid  input  1  input request valid.
- o_ready  output  1  input request accepted when high together with i_valid.
- i_bits  input  WIDTH  vector to search.
- i_from_msb  input  1  1: count from bit WIDTH-1 downward; 0: count from bit 0 upward.
- i_count_ones  input  1  0: count leading zeros (stop at first 1); 1: count leading ones (stop at first 0).
- o_valid  output  1  result valid.
- i_ready  input  1  result consumed when high together with o_valid.
- o_count  output  COUNT_WIDTH  number of leading zeros/ones.
- o_all  output  1  no hit found in the whole vector (o_count == WIDTH).

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: state=IDLE, o_ready=1, o_valid=0, o_count=0, o_all=0, chunk index=0, data register=0.
- i_clear has the same effect as reset on state, o_valid and the chunk index. The result registers keep their values but are don't-care. i_rst and i_clear take priority over every other event.
- States and transitions:
  - IDLE: o_ready=1. On i_valid&&o_ready, latch the normalised vector and go to SCAN with idx=0.
  - Normalisation at latch: bit-reverse i_bits when i_from_msb=1, so scanning always proceeds from bit 0 upward. Invert when i_count_ones=1. Mode inputs are sampled only at accept.
  - SCAN: o_ready=0. Examine slice idx (bits idx*CHUNK .. idx*CHUNK+CHUNK-1).
    - Slice nonzero: o_count = idx*CHUNK + position of the lowest set bit in the slice; o_all=0; go to DONE.
    - Slice zero and idx==CHUNKS-1: o_count=WIDTH; o_all=1; go to DONE.
    - Otherwise idx++.
  - DONE: o_valid=1, o_ready=0. Result stays stable while i_ready=0. On i_ready, go to IDLE.
- Latency: request accepted at edge t. A hit in slice k makes o_valid high in the cycle after edge t+k+1. First-slice hit: o_valid visible 2 cycles after the accept cycle. Worst case (no hit): CHUNKS+1 cycles.
- Throughput: at most one request in flight. No new accept occurs in the same cycle as the result handshake, because o_ready goes high only in IDLE, the cycle after the DONE handshake.
- Partial last slice (WIDTH % CHUNK != 0): bits beyond WIDTH-1 read as 0 after normalisation. o_count can therefore never exceed WIDTH.
- Width rules: idx*CHUNK + local position is computed at COUNT_WIDTH. It never overflows because the maximum in-range value is WIDTH-1.
- Handshake rules:
  - i_valid may drop without acceptance; no state change results.
  - i_bits and mode inputs are ignored outside the accept cycle.
  - o_valid must not drop until i_ready is seen, unless i_rst or i_clear is asserted.
- Simultaneous events:
  - i_clear and i_valid in IDLE: request is not accepted.
  - i_clear and i_ready in DONE: result is dropped; next state is IDLE.
- CHUNK==WIDTH: single scan step; behaves as a 2-cycle registered LZD.

Test Plan:
- Reset, then WIDTH=64, CHUNK=16, i_from_msb=1, i_count_ones=0, i_bits=64'h0000_0000_0010_0000 -> hit in slice 2, o_count=43, o_all=0, o_valid 4 cycles after the accept cycle.
- i_bits=64'h8000_0000_0000_0000, from_msb=1 -> o_count=0, first-slice latency of 2 cycles. Same vector with from_msb=0 -> o_count=63, slice 3.
- i_bits=0, count_ones=0 -> o_count=64, o_all=1 after CHUNKS+1=5 cycles. i_bits='1 with count_ones=1 -> identical response.
- i_bits=64'hFFFF_FFFF_FFF0_FFFF, count_ones=1, from_msb=0 -> o_count=16. Hold i_ready=0 for 10 cycles -> o_valid and o_count stay stable and o_ready stays 0.
- WIDTH=20, CHUNK=8 (partial slice): i_bits=0 -> o_count=20, o_all=1. i_bits=20'h00001 with from_msb=1 -> o_count=19.
- Assert i_clear during SCAN at idx=1 -> o_valid never rises and o_ready=1 next cycle. A new request accepted right after returns its own correct count. Assert i_rst mid-DONE -> o_valid=0 next cycle.
